// File: rtl/timer_periph.sv
// Memory-mapped timer: reload (TH), counter (TL), control (TCON), prescaler, level IRQ.
// Optional free-running SYSTICK counter, built only when TIMER_SYSTICK_EN is defined.
module timer_periph (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [31:0] ReadData,
  output logic        irq
);

  localparam int unsigned DW = 32;
  localparam int unsigned PW = 16;
  localparam int unsigned OW = 3;
  localparam int unsigned HW = 27;

  localparam logic [HW-1:0] BASE_HI     = 27'h200_0000;
  localparam logic [OW-1:0] OFF_TH      = 3'd0;
  localparam logic [OW-1:0] OFF_TL      = 3'd1;
  localparam logic [OW-1:0] OFF_TCON    = 3'd2;
  localparam logic [OW-1:0] OFF_PRESC   = 3'd3;
  localparam logic [OW-1:0] OFF_SYSTICK = 3'd5;
  localparam logic [DW-1:0] TL_MAX      = '1;

  logic [DW-1:0] th, th_n;
  logic [DW-1:0] tl, tl_n;
  logic          en, en_n;
  logic          ie, ie_n;
  logic          st, st_n;
  logic [PW-1:0] presc, presc_n;
  logic [PW-1:0] pcnt, pcnt_n;
  logic [DW-1:0] systick_val;

  logic          hit;
  logic [OW-1:0] off;
  logic          wr_th, wr_tl, wr_tcon, wr_presc;
  logic          tick, ovf, st_set;
  logic          unused_addr;

  // Window decode; the byte lane bits are irrelevant for word registers.
  assign hit         = (Address[DW-1:5] == BASE_HI);
  assign off         = Address[4:2];
  assign unused_addr = ^Address[1:0];

  assign wr_th    = MemWrite & hit & (off == OFF_TH);
  assign wr_tl    = MemWrite & hit & (off == OFF_TL);
  assign wr_tcon  = MemWrite & hit & (off == OFF_TCON);
  assign wr_presc = MemWrite & hit & (off == OFF_PRESC);

  // A TL write in a tick cycle suppresses both the increment and the overflow event.
  assign tick   = en & (pcnt == presc);
  assign ovf    = tick & (tl == TL_MAX) & ~wr_tl;
  assign st_set = ovf & ie;

  always_comb begin
    th_n    = th;
    tl_n    = tl;
    en_n    = en;
    ie_n    = ie;
    st_n    = st | st_set;
    presc_n = presc;
    pcnt_n  = pcnt;

    if (en) begin
      pcnt_n = tick ? '0 : pcnt + PW'(1);
    end
    if (wr_presc) begin
      presc_n = WriteData[PW-1:0];
      pcnt_n  = '0;
    end

    // Reload uses the current TH even if TH is being written this cycle.
    if (wr_tl) begin
      tl_n = WriteData;
    end else if (tick) begin
      tl_n = ovf ? th : tl + DW'(1);
    end
    if (wr_th) begin
      th_n = WriteData;
    end

    // An overflow in the same cycle as a TCON write still sets ST.
    if (wr_tcon) begin
      en_n = WriteData[0];
      ie_n = WriteData[1];
      st_n = WriteData[2] | st_set;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      th    <= '0;
      tl    <= '0;
      en    <= 1'b0;
      ie    <= 1'b0;
      st    <= 1'b0;
      presc <= '0;
      pcnt  <= '0;
      irq   <= 1'b0;
    end else begin
      th    <= th_n;
      tl    <= tl_n;
      en    <= en_n;
      ie    <= ie_n;
      st    <= st_n;
      presc <= presc_n;
      pcnt  <= pcnt_n;
      irq   <= ie_n & st_n;
    end
  end

`ifdef TIMER_SYSTICK_EN
  logic [DW-1:0] systick;

  // Free-running cycle counter, independent of EN.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      systick <= '0;
    end else begin
      systick <= systick + DW'(1);
    end
  end

  assign systick_val = systick;
`else
  assign systick_val = '0;
`endif

  // Load data path: zero unless a load hits a mapped register.
  always_comb begin
    ReadData = '0;
    if (MemRead && hit) begin
      case (off)
        OFF_TH:      ReadData = th;
        OFF_TL:      ReadData = tl;
        OFF_TCON:    ReadData = DW'({st, ie, en});
        OFF_PRESC:   ReadData = DW'(presc);
        OFF_SYSTICK: ReadData = systick_val;
        default:     ReadData = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_periph.sv
// Self-checking bench for timer_periph: directed register scenarios plus random bus traffic
// compared against a cycle-level behavioural model. Honours TIMER_SYSTICK_EN.
module tb_timer_periph;

  localparam logic [31:0] A_TH      = 32'h4000_0000;
  localparam logic [31:0] A_TL      = 32'h4000_0004;
  localparam logic [31:0] A_TCON    = 32'h4000_0008;
  localparam logic [31:0] A_PRESC   = 32'h4000_000C;
  localparam logic [31:0] A_SYSTICK = 32'h4000_0014;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] ReadData;
  logic        irq;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  logic [31:0] m_th, m_tl, m_systick;
  logic [15:0] m_presc, m_pcnt;
  logic        m_en, m_ie, m_st;

  timer_periph dut (
    .clk(clk),
    .reset(reset),
    .Address(Address),
    .WriteData(WriteData),
    .MemRead(MemRead),
    .MemWrite(MemWrite),
    .ReadData(ReadData),
    .irq(irq)
  );

  always #10 clk = ~clk;

  function automatic void m_reset();
    m_th = '0; m_tl = '0; m_systick = '0;
    m_presc = '0; m_pcnt = '0;
    m_en = 1'b0; m_ie = 1'b0; m_st = 1'b0;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (a[31:5] != 27'h200_0000) return 32'h0;
    case (a[4:2])
      3'd0: return m_th;
      3'd1: return m_tl;
      3'd2: return {29'd0, m_st, m_ie, m_en};
      3'd3: return {16'd0, m_presc};
      3'd5: return m_systick;
      default: return 32'h0;
    endcase
  endfunction

  // One rising edge of the timer, as described by the register rules.
  function automatic void m_clock(input logic we, input logic [31:0] a, input logic [31:0] d);
    logic       in_win, tick, wrap, ev;
    logic [2:0] off;
    in_win = (a[31:5] == 27'h200_0000);
    off    = a[4:2];
    tick   = m_en && (m_pcnt == m_presc);
    wrap   = tick && (m_tl == 32'hFFFF_FFFF) && !(we && in_win && off == 3'd1);
    ev     = wrap && m_ie;
    if (m_en) m_pcnt = tick ? 16'd0 : m_pcnt + 16'd1;
    if (tick) m_tl = wrap ? m_th : m_tl + 32'd1;
    m_st = m_st | ev;
    if (we && in_win) begin
      case (off)
        3'd0: m_th = d;
        3'd1: m_tl = d;
        3'd2: begin m_en = d[0]; m_ie = d[1]; m_st = d[2] | ev; end
        3'd3: begin m_presc = d[15:0]; m_pcnt = 16'd0; end
        default: ;
      endcase
    end
`ifdef TIMER_SYSTICK_EN
    m_systick = m_systick + 32'd1;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    if (reset === 1'b1) m_clock(MemWrite, Address, WriteData);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    Address = a; WriteData = d; MemWrite = 1'b1;
    step();
    MemWrite = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] q);
    Address = a; MemRead = 1'b1;
    #1;
    q = ReadData;
    MemRead = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] q;
    #1 reset = 1'b0;
    m_reset();
    Address = A_TL; WriteData = 32'h1234_5678; MemWrite = 1'b1;
    repeat (3) step();
    MemWrite = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rd(A_TH + 32'(i * 4), q);
      checks++;
      if (q !== 32'h0) begin errors++; $display("FAIL reset_read[%0d]: got %h expected %h", i, q, 32'h0); end
    end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
    reset = 1'b1;
    repeat (3) step();
    for (int i = 0; i < 6; i++) begin
      rd(A_TH + 32'(i * 4), q);
      checks++;
      if (q !== m_read(A_TH + 32'(i * 4)))
        begin errors++; $display("FAIL post_reset_read[%0d]: got %h expected %h", i, q, m_read(A_TH + 32'(i * 4))); end
    end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL post_reset_irq: got %b expected 0", irq); end
  endtask

  task automatic test_overflow();
    logic [31:0] q;
    wr(A_TH, 32'hFFFF_FFFC);
    wr(A_TL, 32'hFFFF_FFFE);
    wr(A_PRESC, 32'h0);
    wr(A_TCON, 32'h3);
    step();
    rd(A_TL, q);
    checks++;
    if (q !== 32'hFFFF_FFFF) begin errors++; $display("FAIL ovf_tl_max: got %h expected %h", q, 32'hFFFF_FFFF); end
    step();
    rd(A_TL, q);
    checks++;
    if (q !== 32'hFFFF_FFFC) begin errors++; $display("FAIL ovf_tl_reload: got %h expected %h", q, 32'hFFFF_FFFC); end
    rd(A_TCON, q);
    checks++;
    if (q !== 32'h7) begin errors++; $display("FAIL ovf_tcon: got %h expected %h", q, 32'h7); end
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL ovf_irq: got %b expected 1", irq); end
    step();
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL ovf_irq_hold: got %b expected 1", irq); end
    wr(A_TCON, 32'h0);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL ovf_irq_clear: got %b expected 0", irq); end
  endtask

  task automatic test_prescaler();
    logic [31:0] q;
    logic [31:0] exp;
    wr(A_PRESC, 32'h3);
    wr(A_TL, 32'h0);
    wr(A_TCON, 32'h1);
    for (int e = 1; e <= 12; e++) begin
      step();
      if (e == 3 || e == 4 || e == 8 || e == 11 || e == 12) begin
        exp = 32'(e / 4);
        rd(A_TL, q);
        checks++;
        if (q !== exp) begin errors++; $display("FAIL presc_tl_e%0d: got %h expected %h", e, q, exp); end
      end
    end
    wr(A_TCON, 32'h0);
    repeat (10) step();
    rd(A_TL, q);
    checks++;
    if (q !== 32'h3) begin errors++; $display("FAIL presc_hold: got %h expected %h", q, 32'h3); end
  endtask

  task automatic test_tcon_ovf();
    logic [31:0] q;
    wr(A_PRESC, 32'h0);
    wr(A_TH, 32'h100);
    wr(A_TL, 32'hFFFF_FFFE);
    wr(A_TCON, 32'h3);
    step();
    wr(A_TCON, 32'h3);
    rd(A_TL, q);
    checks++;
    if (q !== 32'h100) begin errors++; $display("FAIL tcon_ovf_tl: got %h expected %h", q, 32'h100); end
    rd(A_TCON, q);
    checks++;
    if (q !== 32'h7) begin errors++; $display("FAIL tcon_ovf_st: got %h expected %h", q, 32'h7); end
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL tcon_ovf_irq: got %b expected 1", irq); end
    repeat (3) step();
    rd(A_TCON, q);
    checks++;
    if (q !== 32'h7) begin errors++; $display("FAIL tcon_st_sticky: got %h expected %h", q, 32'h7); end
    wr(A_TCON, 32'h3);
    rd(A_TCON, q);
    checks++;
    if (q !== 32'h3) begin errors++; $display("FAIL tcon_st_clear: got %h expected %h", q, 32'h3); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL tcon_irq_clear: got %b expected 0", irq); end
    wr(A_TCON, 32'h0);
  endtask

  task automatic test_tl_wins();
    logic [31:0] q;
    wr(A_TL, 32'hFFFF_FFFE);
    wr(A_TCON, 32'h3);
    step();
    wr(A_TL, 32'h10);
    rd(A_TL, q);
    checks++;
    if (q !== 32'h10) begin errors++; $display("FAIL tlwin_tl: got %h expected %h", q, 32'h10); end
    rd(A_TCON, q);
    checks++;
    if (q !== 32'h3) begin errors++; $display("FAIL tlwin_st: got %h expected %h", q, 32'h3); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL tlwin_irq: got %b expected 0", irq); end
    step();
    rd(A_TL, q);
    checks++;
    if (q !== 32'h11) begin errors++; $display("FAIL tlwin_next: got %h expected %h", q, 32'h11); end
    // TH write in the overflow cycle: reload takes the previous TH.
    wr(A_TH, 32'h200);
    wr(A_TL, 32'hFFFF_FFFF);
    wr(A_TH, 32'h55);
    rd(A_TL, q);
    checks++;
    if (q !== 32'h200) begin errors++; $display("FAIL th_old_reload: got %h expected %h", q, 32'h200); end
    rd(A_TH, q);
    checks++;
    if (q !== 32'h55) begin errors++; $display("FAIL th_new: got %h expected %h", q, 32'h55); end
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL th_ovf_irq: got %b expected 1", irq); end
    wr(A_TCON, 32'h0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 1500; n++) begin
      logic [31:0] a, d, exp;
      logic        we, re;
      a = A_TH | (32'($urandom_range(0, 7)) << 2);
      if ($urandom_range(0, 15) == 0) a = $urandom;
      else if ($urandom_range(0, 31) == 0) a = 32'h4000_0020;
      d = $urandom;
      if (a == A_TL && $urandom_range(0, 1) == 1) d = 32'hFFFF_FFF0 | (d & 32'hF);
      if (a == A_PRESC && $urandom_range(0, 3) != 0) d = d & 32'h3;
      we = ($urandom_range(0, 3) == 0);
      re = $urandom_range(0, 1) == 1;
      Address = a; WriteData = d; MemWrite = we; MemRead = re;
      #1;
      exp = re ? m_read(a) : 32'h0;
      checks++;
      if (ReadData !== exp) begin errors++; $display("FAIL rand_read[%0d] @%h: got %h expected %h", n, a, ReadData, exp); end
      checks++;
      if (irq !== (m_ie & m_st)) begin errors++; $display("FAIL rand_irq[%0d]: got %b expected %b", n, irq, m_ie & m_st); end
      step();
    end
    MemWrite = 1'b0; MemRead = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] q;
    logic [31:0] exp_systick;
    wr(A_TCON, 32'h0);
    wr(A_PRESC, 32'h0);
    wr(A_TH, 32'h0);
    wr(A_TL, 32'hFFFF_FFFF);
    wr(A_TCON, 32'h3);
    step();
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL midrst_pre_irq: got %b expected 1", irq); end
    #5 reset = 1'b0;
    m_reset();
    #1;
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL midrst_irq: got %b expected 0", irq); end
    rd(A_TL, q);
    checks++;
    if (q !== 32'h0) begin errors++; $display("FAIL midrst_tl: got %h expected %h", q, 32'h0); end
    rd(A_TCON, q);
    checks++;
    if (q !== 32'h0) begin errors++; $display("FAIL midrst_tcon: got %h expected %h", q, 32'h0); end
    repeat (3) step();
    #4 reset = 1'b1;
    repeat (100) step();
`ifdef TIMER_SYSTICK_EN
    exp_systick = 32'd100;
`else
    exp_systick = 32'd0;
`endif
    rd(A_SYSTICK, q);
    checks++;
    if (q !== exp_systick) begin errors++; $display("FAIL systick_100: got %h expected %h", q, exp_systick); end
    rd(A_TL, q);
    checks++;
    if (q !== 32'h0) begin errors++; $display("FAIL midrst_tl_idle: got %h expected %h", q, 32'h0); end
  endtask

  initial begin
    Address = '0; WriteData = '0; MemRead = 1'b0; MemWrite = 1'b0;
    m_reset();
    test_reset();
    test_overflow();
    test_prescaler();
    test_tcon_ovf();
    test_tl_wins();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/timer_periph.md
TIMER_PERIPH -- requirements
Module: timer_periph

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset, with ports named clk and reset as elsewhere in the codebase.
REQ-002 clk  input  1  rising-edge clock shared with the CPU pipeline.
REQ-003 reset  input  1  asynchronous, active-low; low clears all state immediately.
REQ-004 Address  input  32  byte address from the memory-stage ALU result.
REQ-005 WriteData  input  32  store data from the memory stage.
REQ-006 MemRead  input  1  load strobe.
REQ-007 MemWrite  input  1  store strobe, sampled on the clk rising edge.
REQ-008 ReadData  output  32  load data, combinational from Address and MemRead.
REQ-009 irq  output  1  interrupt request, level, registered.

Function
REQ-010 The block SHALL decode Address[31:5]==0x40000000>>5 as its window; the register is selected by Address[4:2].
REQ-011 Register map SHALL be: TH 0x40000000 (reload value, 32b); TL 0x40000004 (counter, 32b); TCON 0x40000008 (bit0 EN, bit1 IE, bit2 ST, others read 0); PRESC 0x4000000C (16b, upper bits read 0); SYSTICK 0x40000014 (32b, read-only).
REQ-012 ReadData SHALL be the selected register when MemRead=1 and the address hits the window; otherwise ReadData SHALL be 0. Unmapped offsets SHALL read 0.
REQ-013 Writes SHALL take effect on the clk edge where MemWrite=1; writes to unmapped offsets or SYSTICK SHALL be ignored.
REQ-014 Prescaler: a 16-bit pcnt SHALL run only while EN=1. Each cycle, if pcnt==PRESC, pcnt<=0 and a tick is generated; otherwise pcnt<=pcnt+1. PRESC=0 SHALL give a tick every cycle.
REQ-015 With EN=0, pcnt and TL SHALL hold.
REQ-016 A write to PRESC SHALL also clear pcnt.
REQ-017 On tick: if TL==0xFFFFFFFF, TL<=TH (overflow event); else TL<=TL+1. Wrap SHALL never pass through 0 unless TH=0.
REQ-018 Overflow event with IE=1 SHALL set ST on the same edge that TL reloads.
REQ-019 irq SHALL be IE&ST from the registered bits, so irq is asserted in the cycle after the reload edge.
REQ-020 A TL write in the same cycle as a tick SHALL win: TL takes WriteData, and there is no increment and no overflow event.
REQ-021 A TH write in an overflow cycle SHALL be followed by a reload using the old TH.
REQ-022 A TCON write SHALL load EN and IE from WriteData[1:0]; ST SHALL become WriteData[2] OR the overflow-set condition of that cycle, so an event is never lost.
REQ-023 A write of 0 to TCON[2] SHALL be the only way to clear ST, apart from reset.

Reset
REQ-024 While reset=0, TH, TL, TCON, PRESC, pcnt and SYSTICK SHALL be 0 and irq SHALL be 0, asynchronously, without waiting for a clock edge.
REQ-025 ReadData SHALL follow the cleared registers during reset.
REQ-026 Counting SHALL resume only from the first clk edge after reset returns high.

Configuration
REQ-027 Macro TIMER_SYSTICK_EN SHALL control the SYSTICK counter.
REQ-028 With TIMER_SYSTICK_EN defined: SYSTICK increments by 1 every clk edge out of reset, regardless of EN, and wraps 0xFFFFFFFF->0.
REQ-029 Without TIMER_SYSTICK_EN: no SYSTICK register is built, and offset 0x14 reads 0.

Verification
REQ-030 Reset low, then read all offsets -> every read is 0 and irq=0; release reset -> values stay 0 with EN=0.
REQ-031 Write TH=0xFFFFFFFC, TL=0xFFFFFFFE, PRESC=0, TCON=0x3 -> TL=0xFFFFFFFF after 1 edge; next edge TL=0xFFFFFFFC and TCON reads 0x7; irq=1 in the following cycle.
REQ-032 Write PRESC=3, TL=0, TCON=0x1 -> TL reads 1, 2, 3 after 4, 8 and 12 edges; TCON=0 afterwards -> TL holds at 3.
REQ-033 In an overflow cycle, write TCON=0x3 -> TCON reads 0x7 and irq=1; a later write of TCON=0x3 -> TCON reads 0x3 and irq=0.
REQ-034 In a tick cycle with TL=0xFFFFFFFF and IE=1, write TL=0x10 -> TL=0x10, ST stays 0, irq stays 0.
REQ-035 Pull reset low mid-count with irq=1 -> TL=0, TCON=0 and irq=0 before the next edge; with TIMER_SYSTICK_EN, 100 edges after release SYSTICK reads 100 (0 without the macro).
